// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared types and constants for the writeback unit: load-size
//            codes, the buffered result entry and the FIFO depth check.
// Revision : 1.0  initial release
// ============================================================================
package wb_pkg;

  // Load size encodings as presented by the MEM stage (2'b11 acts as word)
  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_BYTE = 2'b10;

  // Widths the buffered entry is built for
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  // One buffered result; data is already formatted when it is stored
  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic                 reg_write;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  // FIFO depth must be a power of two so pointers wrap naturally
  function automatic bit depth_is_legal(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_load_align.sv
`default_nettype none
// ============================================================================
// Module   : wb_load_align
// Purpose  : Combinational load formatter. Picks the addressed byte or half
//            lane of a little-endian memory word and sign/zero extends it.
// Revision : 1.0  initial release
// ============================================================================
module wb_load_align
  import wb_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_byte_ext;
  logic        w_half_ext;

  // Byte lane follows the full offset; half lane only uses offset[1] since
  // misaligned halves never reach this stage
  assign w_byte     = i_data[{i_offset, 3'b000} +: 8];
  assign w_half     = i_offset[1] ? i_data[31:16] : i_data[15:0];
  assign w_byte_ext = ~i_unsigned & w_byte[7];
  assign w_half_ext = ~i_unsigned & w_half[15];

  // Select the formatted result by load size; word and the spare code pass through
  always_comb begin
    o_data = i_data;
    case (i_size)
      LS_BYTE: o_data = {{24{w_byte_ext}}, w_byte};
      LS_HALF: o_data = {{16{w_half_ext}}, w_half};
      LS_WORD: o_data = i_data;
      default: o_data = i_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit
// Purpose  : Register-file writer. Buffers MEM-stage results in a small FIFO,
//            formats loads on entry, drives a registered write port and
//            offers two forwarding lookups over buffered/in-flight results.
// Revision : 1.0  initial release
// ============================================================================
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // MEM-stage result handshake
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [1:0]        mem_load_size,
  input  logic              mem_load_unsigned,
  input  logic [1:0]        mem_byte_offset,
  // Register file write port
  input  logic              wb_hold,
  output logic [ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0] write_data,
  output logic              write_enable,
  // Forwarding lookups
  input  logic [ADDR_W-1:0] fwd_rs_addr,
  input  logic [ADDR_W-1:0] fwd_rt_addr,
  output logic              fwd_rs_hit,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic [DATA_W-1:0] fwd_rt_data
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  // Reject parameter sets the entry layout cannot represent
  if (!depth_is_legal(DEPTH) || (ADDR_W != WB_ADDR_W) || (DATA_W != WB_DATA_W)) begin : g_bad_param
    $error("writeback_unit: DEPTH must be a power of two >= 2, ADDR_W=5, DATA_W=32");
  end

  wb_entry_t        r_fifo [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_load_fmt;
  wb_entry_t        w_new_entry;
  wb_entry_t        w_head;

  wb_load_align u_load_align (
    .i_data     (mem_load_data),
    .i_size     (mem_load_size),
    .i_offset   (mem_byte_offset),
    .i_unsigned (mem_load_unsigned),
    .o_data     (w_load_fmt)
  );

  // Ready depends only on occupancy, so wb_hold never reaches mem_ready
  assign mem_ready = (r_count < C_DEPTH);
  assign w_push    = mem_valid && mem_ready;
  // No bypass: an empty FIFO never pops, even while a push is arriving
  assign w_pop     = (r_count != '0) && !wb_hold;

  assign w_new_entry.rd        = mem_rd;
  assign w_new_entry.reg_write = mem_reg_write;
  assign w_new_entry.data      = mem_to_reg ? w_load_fmt : mem_alu_result;
  assign w_head                = r_fifo[r_rd_ptr];

  // Entry storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_new_entry;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards every buffered entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered write port; entries for r0 or without reg_write drain silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_enable   <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else if (w_pop) begin
      write_enable   <= w_head.reg_write && (w_head.rd != '0);
      write_register <= w_head.rd;
      write_data     <= w_head.data;
    end else begin
      write_enable   <= 1'b0;
    end
  end

  // Forwarding search: output stage first, then FIFO oldest to newest so the
  // youngest matching result is the one left standing
  always_comb begin : fwd_search
    logic [PTR_W-1:0] v_idx;
    fwd_rs_hit  = 1'b0;
    fwd_rs_data = '0;
    fwd_rt_hit  = 1'b0;
    fwd_rt_data = '0;
    v_idx       = '0;

    if (write_enable && (write_register == fwd_rs_addr)) begin
      fwd_rs_hit  = 1'b1;
      fwd_rs_data = write_data;
    end
    if (write_enable && (write_register == fwd_rt_addr)) begin
      fwd_rt_hit  = 1'b1;
      fwd_rt_data = write_data;
    end

    for (int k = 0; k < DEPTH; k++) begin
      v_idx = r_rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && r_fifo[v_idx].reg_write) begin
        if (r_fifo[v_idx].rd == fwd_rs_addr) begin
          fwd_rs_hit  = 1'b1;
          fwd_rs_data = r_fifo[v_idx].data;
        end
        if (r_fifo[v_idx].rd == fwd_rt_addr) begin
          fwd_rt_hit  = 1'b1;
          fwd_rt_data = r_fifo[v_idx].data;
        end
      end
    end

    // r0 is hardwired to zero and is never forwarded
    if (fwd_rs_addr == '0) begin
      fwd_rs_hit  = 1'b0;
      fwd_rs_data = '0;
    end
    if (fwd_rt_addr == '0) begin
      fwd_rt_hit  = 1'b0;
      fwd_rt_data = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_unit
// Purpose  : Directed self-checking bench for writeback_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_writeback_unit;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_to_reg;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic [1:0]  mem_load_size;
  logic        mem_load_unsigned;
  logic [1:0]  mem_byte_offset;
  logic        wb_hold;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        write_enable;
  logic [4:0]  fwd_rs_addr;
  logic [4:0]  fwd_rt_addr;
  logic        fwd_rs_hit;
  logic        fwd_rt_hit;
  logic [31:0] fwd_rs_data;
  logic [31:0] fwd_rt_data;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  writeback_unit #(.DEPTH(2), .ADDR_W(5), .DATA_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem_valid         (mem_valid),
    .mem_ready         (mem_ready),
    .mem_rd            (mem_rd),
    .mem_reg_write     (mem_reg_write),
    .mem_to_reg        (mem_to_reg),
    .mem_alu_result    (mem_alu_result),
    .mem_load_data     (mem_load_data),
    .mem_load_size     (mem_load_size),
    .mem_load_unsigned (mem_load_unsigned),
    .mem_byte_offset   (mem_byte_offset),
    .wb_hold           (wb_hold),
    .write_register    (write_register),
    .write_data        (write_data),
    .write_enable      (write_enable),
    .fwd_rs_addr       (fwd_rs_addr),
    .fwd_rt_addr       (fwd_rt_addr),
    .fwd_rs_hit        (fwd_rs_hit),
    .fwd_rt_hit        (fwd_rt_hit),
    .fwd_rs_data       (fwd_rs_data),
    .fwd_rt_data       (fwd_rt_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic rw, input logic m2r,
                      input logic [31:0] alu, input logic [31:0] ld,
                      input logic [1:0] sz, input logic uns, input logic [1:0] off);
    mem_valid         = 1'b1;
    mem_rd            = rd;
    mem_reg_write     = rw;
    mem_to_reg        = m2r;
    mem_alu_result    = alu;
    mem_load_data     = ld;
    mem_load_size     = sz;
    mem_load_unsigned = uns;
    mem_byte_offset   = off;
    step();
    mem_valid         = 1'b0;
  endtask

  task automatic push_alu(input logic [4:0] rd, input logic [31:0] alu);
    push(rd, 1'b1, 1'b0, alu, 32'h0, LS_WORD, 1'b0, 2'd0);
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_vecs [9] = '{
    '{2'b10, 1'b0, 2'd3, 32'hFFFFFF80},
    '{2'b10, 1'b1, 2'd3, 32'h00000080},
    '{2'b01, 1'b0, 2'd2, 32'hFFFF80FF},
    '{2'b01, 1'b1, 2'd2, 32'h000080FF},
    '{2'b10, 1'b0, 2'd1, 32'h0000007F},
    '{2'b10, 1'b0, 2'd2, 32'hFFFFFFFF},
    '{2'b01, 1'b0, 2'd1, 32'h00007F01},
    '{2'b11, 1'b0, 2'd3, 32'h80FF7F01},
    '{2'b00, 1'b1, 2'd2, 32'h80FF7F01}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_valid = 1'b0; mem_rd = '0; mem_reg_write = 1'b0;
    mem_to_reg = 1'b0; mem_alu_result = '0; mem_load_data = '0;
    mem_load_size = '0; mem_load_unsigned = 1'b0; mem_byte_offset = '0;
    wb_hold = 1'b0; fwd_rs_addr = '0; fwd_rt_addr = '0;

    // Reset state
    repeat (2) step();
    chk("rst_we", write_enable, 0);
    chk("rst_wr", write_register, 0);
    chk("rst_wd", write_data, 0);
    chk("rst_ready", mem_ready, 1);
    rst_n = 1'b1;
    step();

    // ALU result: one-cycle latency, single-cycle strobe, data holds
    push_alu(5'd8, 32'h12345678);
    chk("alu_lat_we", write_enable, 0);
    step();
    chk("alu_we", write_enable, 1);
    chk("alu_wr", write_register, 8);
    chk("alu_wd", write_data, 32'h12345678);
    step();
    chk("alu_we_drop", write_enable, 0);
    chk("alu_wd_hold", write_data, 32'h12345678);

    // Load formatting table
    for (int i = 0; i < 9; i++) begin
      push(5'(i + 1), 1'b1, 1'b1, 32'hDEADBEEF, 32'h80FF7F01,
           ld_vecs[i].sz, ld_vecs[i].uns, ld_vecs[i].off);
      step();
      chk($sformatf("load%0d_wd", i), write_data, ld_vecs[i].exp);
      chk($sformatf("load%0d_wr", i), write_register, 32'(i + 1));
    end
    step();

    // Streaming: push every cycle, writes follow one per cycle
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1; mem_rd = 5'(12 + i); mem_reg_write = 1'b1;
      mem_to_reg = 1'b0; mem_alu_result = 32'hC0 + 32'(16 * i);
      step();
      if (i > 0) begin
        chk($sformatf("strm%0d_wd", i), write_data, 32'hC0 + 32'(16 * (i - 1)));
        chk($sformatf("strm%0d_ready", i), mem_ready, 1);
      end
    end
    mem_valid = 1'b0;
    step();
    chk("strm_last_wd", write_data, 32'hE0);
    chk("strm_last_we", write_enable, 1);
    step();
    chk("strm_idle_we", write_enable, 0);

    // Backpressure: third push refused while full
    wb_hold = 1'b1;
    push_alu(5'd2, 32'h22);
    chk("bp_ready1", mem_ready, 1);
    push_alu(5'd3, 32'h33);
    chk("bp_full", mem_ready, 0);
    push_alu(5'd4, 32'h44);
    chk("bp_held_we", write_enable, 0);
    chk("bp_still_full", mem_ready, 0);
    wb_hold = 1'b0;
    step();
    chk("bp_w1_we", write_enable, 1);
    chk("bp_w1_wr", write_register, 2);
    chk("bp_w1_wd", write_data, 32'h22);
    step();
    chk("bp_w2_we", write_enable, 1);
    chk("bp_w2_wr", write_register, 3);
    chk("bp_w2_wd", write_data, 32'h33);
    step();
    chk("bp_no_third", write_enable, 0);

    // Forwarding: newest wins, r0 never hits, output stage covered
    wb_hold = 1'b1;
    push_alu(5'd5, 32'hA);
    push_alu(5'd5, 32'hB);
    fwd_rs_addr = 5'd5; fwd_rt_addr = 5'd0;
    #1;
    chk("fwd_rs_hit", fwd_rs_hit, 1);
    chk("fwd_rs_data", fwd_rs_data, 32'hB);
    chk("fwd_r0_hit", fwd_rt_hit, 0);
    chk("fwd_r0_data", fwd_rt_data, 0);
    wb_hold = 1'b0;
    step();
    chk("fwd_mix_data", fwd_rs_data, 32'hB);
    step();
    chk("fwd_out_hit", fwd_rs_hit, 1);
    chk("fwd_out_data", fwd_rs_data, 32'hB);
    step();
    chk("fwd_gone_hit", fwd_rs_hit, 0);
    chk("fwd_gone_data", fwd_rs_data, 0);

    wb_hold = 1'b1;
    push_alu(5'd6, 32'h60);
    push_alu(5'd7, 32'h70);
    fwd_rs_addr = 5'd6; fwd_rt_addr = 5'd7;
    #1;
    chk("fwd_old_data", fwd_rs_data, 32'h60);
    chk("fwd_new_data", fwd_rt_data, 32'h70);
    wb_hold = 1'b0;
    repeat (3) step();

    // r0 and reg_write=0 entries: drained silently, never forwarded
    wb_hold = 1'b1;
    push(5'd0, 1'b1, 1'b0, 32'hDEAD, 32'h0, LS_WORD, 1'b0, 2'd0);
    push(5'd9, 1'b0, 1'b0, 32'hBEEF, 32'h0, LS_WORD, 1'b0, 2'd0);
    fwd_rs_addr = 5'd0; fwd_rt_addr = 5'd9;
    #1;
    chk("nw_r0_hit", fwd_rs_hit, 0);
    chk("nw_rw0_hit", fwd_rt_hit, 0);
    wb_hold = 1'b0;
    step();
    chk("nw_r0_we", write_enable, 0);
    step();
    chk("nw_rw0_we", write_enable, 0);
    chk("nw_rw0_wr", write_register, 9);
    chk("nw_drained", mem_ready, 1);

    // Asynchronous reset with two entries buffered
    wb_hold = 1'b1;
    push_alu(5'd10, 32'h100);
    push_alu(5'd11, 32'h110);
    fwd_rs_addr = 5'd10; fwd_rt_addr = 5'd11;
    #1;
    chk("pre_rst_hit", fwd_rs_hit, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_we", write_enable, 0);
    chk("arst_ready", mem_ready, 1);
    chk("arst_rs_hit", fwd_rs_hit, 0);
    chk("arst_rt_hit", fwd_rt_hit, 0);
    chk("arst_wr", write_register, 0);
    chk("arst_wd", write_data, 0);
    #1 rst_n = 1'b1;
    wb_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst_we%0d", i), write_enable, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writer side of the register file: accepts completed MEM-stage results through a valid/ready handshake and buffers them in a small FIFO.
- Formats load data (lane select, sign or zero extension) and drives the register file write port (write_register, write_data, write_enable) with registered outputs.
- Exposes two forwarding lookup ports so decode can see results that are buffered or in flight but not yet written.

Parameters:
- DEPTH, 2, result FIFO entries; power of two, >= 2.
- ADDR_W, 5, register index width.
- DATA_W, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- mem_valid  in  1  MEM result valid.
- mem_ready  out  1  FIFO can accept; equals (count < DEPTH), registered-state only, no combinational path from wb_hold.
- mem_rd  in  ADDR_W  destination register.
- mem_reg_write  in  1  result writes the register file.
- mem_to_reg  in  1  1 = load data, 0 = ALU result.
- mem_alu_result  in  DATA_W  ALU result.
- mem_load_data  in  DATA_W  raw memory word.
- mem_load_size  in  2  00 word, 01 half, 10 byte, 11 treated as word.
- mem_load_unsigned  in  1  zero-extend when set.
- mem_byte_offset  in  2  address[1:0] of the load.
- wb_hold  in  1  write port busy; no pop this cycle.
- write_register  out  ADDR_W  register file write index.
- write_data  out  DATA_W  register file write data.
- write_enable  out  1  register file write strobe.
- fwd_rs_addr, fwd_rt_addr  in  ADDR_W  lookup indices.
- fwd_rs_hit, fwd_rt_hit  out  1  a pending write to that index exists.
- fwd_rs_data, fwd_rt_data  out  DATA_W  newest pending value; 0 when no hit.

Behaviour:
- Reset (async, rst_n=0):
  - count, read and write pointers cleared; buffered entries dropped.
  - write_enable=0, write_register=0, write_data=0.
  - Takes effect mid-operation without waiting for clk.
- Push: mem_valid && mem_ready at posedge stores an entry {rd, reg_write, formatted data}. Formatting happens at push, so each entry holds final data.
- Formatting:
  - mem_to_reg=0: data = mem_alu_result.
  - Byte: lane = mem_byte_offset*8 (little-endian); sign- or zero-extend bit 7.
  - Half: lane = mem_byte_offset[1]*16; offset[0] ignored (misalignment is trapped upstream); extend bit 15.
  - Word: raw data; offset ignored.
- Pop: condition is count>0 && !wb_hold.
  - Outputs register head.rd and head.data.
  - write_enable <= head.reg_write && (head.rd != 0).
  - Entries with reg_write=0 or rd=0 are consumed with write_enable=0.
- No pop: write_enable <= 0. write_register and write_data hold their last values.
- Latency and throughput:
  - An entry pushed at edge N is popped no earlier than edge N+1.
  - The strobe is then visible through that cycle; the register file samples it on the following negedge.
  - Throughput is one per cycle.
- Simultaneous push and pop: allowed when 0 < count < DEPTH; count is unchanged.
  - At count==DEPTH, push is refused even if a pop occurs (mem_ready=0).
  - At count==0, there is no bypass; push and pop are never simultaneous.
- Pointers wrap modulo DEPTH. count has ceil(log2(DEPTH+1)) bits.
- Forwarding (combinational over registered state):
  - Search set: the output stage (when write_enable=1) plus all valid FIFO entries with reg_write=1.
  - Newest match wins: FIFO tail-most entry first, output stage last.
  - Address 0 never hits.

Decomposition:
- Shared package wb_pkg holds:
  - Load size localparams LS_WORD=2'b00, LS_HALF=2'b01, LS_BYTE=2'b10.
  - The wb_entry_t struct {rd, reg_write, data}.
  - DEPTH legality check.
- Sub-module wb_load_align: combinational lane select and extend, taking (data, size, offset, unsigned) and returning the 32-bit result.

Test Plan:
- ALU result: push rd=8, alu=0x12345678, reg_write=1, mem_to_reg=0, wb_hold=0 -> next cycle write_enable=1, write_register=8, write_data=0x12345678; the following cycle write_enable=0.
- Byte load: push load_data=0x80FF7F01, size=byte, offset=3 -> signed gives 0xFFFFFF80, unsigned gives 0x00000080. Half, offset=2, signed -> 0xFFFF80FF.
- Backpressure: hold wb_hold=1 and push 3 -> mem_ready=0 after 2 pushes and the third is not accepted. Release -> writes appear on two consecutive cycles in push order.
- Forwarding: buffer rd=5=0xA then rd=5=0xB with wb_hold=1, query rs=5 -> hit, data 0xB. Query 0 -> hit=0, data 0.
- rd=0 and reg_write=0 entries: push each -> popped with write_enable=0 and never forwarded.
- Reset: deassert rst_n asynchronously with 2 entries buffered -> write_enable=0, mem_ready=1, hits=0 immediately, and no writes occur after release.
